// File: rtl/sigbank_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : sigbank_buffer
//  Purpose  : Banked IQ sample buffer. Whole banks are filled from the input
//             stream, then each full bank is read back TRATE times.
//  Revision : 1.0 - initial release
// ============================================================================
module sigbank_buffer #(
  parameter int WIDTH = 32,
  parameter int TRATE = 30,
  parameter int COUNT = 15,
  parameter int BANKS = 4,
  localparam int TW = (TRATE > 1) ? $clog2(TRATE) : 1,
  localparam int BW = $clog2(BANKS),
  localparam int LW = BW + 1
) (
  input  logic             sig_clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] idata_i,
  input  logic [WIDTH-1:0] qdata_i,
  input  logic             clear_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [TW-1:0]    taddr_o,
  output logic [BW-1:0]    bank_o,
  output logic [WIDTH-1:0] idata_o,
  output logic [WIDTH-1:0] qdata_o,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o
);

  localparam int IW    = $clog2(COUNT);
  localparam int AW    = BW + IW;
  localparam int DEPTH = 1 << AW;

  localparam logic [IW-1:0] c_last_idx  = IW'(COUNT - 1);
  localparam logic [TW-1:0] c_last_pass = TW'(TRATE - 1);
  localparam logic [LW-1:0] c_banks     = LW'(BANKS);

  localparam logic [0:0] c_wr_fill = 1'b0;
  localparam logic [0:0] c_wr_drop = 1'b1;
  localparam logic [0:0] c_rd_idle = 1'b0;
  localparam logic [0:0] c_rd_read = 1'b1;

  logic [2*WIDTH-1:0] r_mem [DEPTH];

  logic [0:0]    r_wr_state;
  logic [0:0]    r_rd_state;
  logic [BW-1:0] r_wbank;
  logic [BW-1:0] r_rbank;
  logic [IW-1:0] r_widx;
  logic [IW-1:0] r_raddr;
  logic [TW-1:0] r_taddr;
  logic [LW-1:0] r_used;
  logic [LW-1:0] w_used_next;

  logic w_write;
  logic w_drop;
  logic w_fill_done;
  logic w_reading;
  logic w_free;

  assign w_write     = (r_wr_state == c_wr_fill) && valid_i;
  assign w_drop      = (r_wr_state == c_wr_drop) && valid_i;
  assign w_fill_done = w_write && (r_widx == c_last_idx);
  assign w_reading   = (r_rd_state == c_rd_read);
  assign w_free      = w_reading && (r_raddr == c_last_idx) && (r_taddr == c_last_pass);

  // A simultaneous fill and free cancel, leaving the count unchanged.
  always_comb begin
    w_used_next = r_used;
    case ({w_fill_done, w_free})
      2'b10:   w_used_next = r_used + LW'(1);
      2'b01:   w_used_next = r_used - LW'(1);
      default: w_used_next = r_used;
    endcase
  end

  always_ff @(posedge sig_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_used <= '0;
    end else begin
      r_used <= w_used_next;
    end
  end

  assign level_o = r_used;

  // Writer: fills the current bank, stalls (dropping input) while all banks are full.
  always_ff @(posedge sig_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state <= c_wr_fill;
      r_wbank    <= '0;
      r_widx     <= '0;
    end else begin
      case (r_wr_state)
        c_wr_fill: begin
          if (w_write) begin
            if (w_fill_done) begin
              r_widx  <= '0;
              r_wbank <= r_wbank + BW'(1);
              if (w_used_next >= c_banks) begin
                r_wr_state <= c_wr_drop;
              end
            end else begin
              r_widx <= r_widx + IW'(1);
            end
          end
        end
        c_wr_drop: begin
          if (r_used < c_banks) begin
            r_wr_state <= c_wr_fill;
            r_widx     <= '0;
          end
        end
        default: r_wr_state <= c_wr_fill;
      endcase
    end
  end

  always_ff @(posedge sig_clk) begin
    if (w_write) begin
      r_mem[{r_wbank, r_widx}] <= {idata_i, qdata_i};
    end
  end

  always_ff @(posedge sig_clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_o <= 1'b0;
    end else if (w_drop) begin
      overflow_o <= 1'b1;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end
  end

  // Reader: TRATE passes over the oldest full bank, chaining banks back-to-back.
  always_ff @(posedge sig_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state <= c_rd_idle;
      r_rbank    <= '0;
      r_raddr    <= '0;
      r_taddr    <= '0;
    end else begin
      case (r_rd_state)
        c_rd_idle: begin
          if (r_used != '0) begin
            r_rd_state <= c_rd_read;
            r_raddr    <= '0;
            r_taddr    <= '0;
          end
        end
        c_rd_read: begin
          if (r_raddr == c_last_idx) begin
            r_raddr <= '0;
            if (r_taddr == c_last_pass) begin
              r_taddr <= '0;
              r_rbank <= r_rbank + BW'(1);
              if (w_used_next == '0) begin
                r_rd_state <= c_rd_idle;
              end
            end else begin
              r_taddr <= r_taddr + TW'(1);
            end
          end else begin
            r_raddr <= r_raddr + IW'(1);
          end
        end
        default: r_rd_state <= c_rd_idle;
      endcase
    end
  end

  // Sideband is registered alongside the synchronous read so all outputs align.
  always_ff @(posedge sig_clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      taddr_o <= '0;
      bank_o  <= '0;
      idata_o <= '0;
      qdata_o <= '0;
    end else begin
      valid_o <= w_reading;
      first_o <= w_reading && (r_raddr == '0) && (r_taddr == '0);
      last_o  <= w_free;
      if (w_reading) begin
        taddr_o            <= r_taddr;
        bank_o             <= r_rbank;
        {idata_o, qdata_o} <= r_mem[{r_rbank, r_raddr}];
      end
    end
  end

endmodule
`default_nettype wire
